// File: rtl/fp_mul_operand_unpack_if.sv
// Operand-pair handshake bundle for the FP multiplier unpack stage.
// The master drives operands and out_ready; the slave (the unpack block)
// returns in_ready and the unpacked fields and flags.
interface fp_mul_operand_unpack_if #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
);

    localparam int unsigned OpW = EXP_W + FRAC_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [OpW-1:0]    op_a;
    logic [OpW-1:0]    op_b;
    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [FRAC_W:0]   man_a;
    logic [FRAC_W:0]   man_b;
    logic              initial_zero_flag;
    logic              initial_inf_flag;
    logic              initial_nan_flag;
    logic              denorm_flushed;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sign_out,
        input  exp_a,
        input  exp_b,
        input  man_a,
        input  man_b,
        input  initial_zero_flag,
        input  initial_inf_flag,
        input  initial_nan_flag,
        input  denorm_flushed
    );

    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sign_out,
        output exp_a,
        output exp_b,
        output man_a,
        output man_b,
        output initial_zero_flag,
        output initial_inf_flag,
        output initial_nan_flag,
        output denorm_flushed
    );

endinterface

// File: rtl/fp_mul_operand_unpack.sv
// Operand unpack and pair classification ahead of the mantissa multiplier.
// Stage 1 captures the raw operand pair; stage 2 holds the unpacked fields
// and the zero/inf/NaN/denormal flags. Both stages stall under backpressure
// through a purely combinational ready chain, so full rate needs no bubbles.
module fp_mul_operand_unpack #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input logic                      CLK,
    input logic                      RST,
    fp_mul_operand_unpack_if.slave   bus_io
);

    localparam int unsigned OpW = EXP_W + FRAC_W + 1;

    // Per-operand classification result.
    typedef struct packed {
        logic            zero;
        logic            den;
        logic            inf;
        logic            nan;
        logic [FRAC_W:0] man;
    } op_class_t;

    // Denormals count as zero (flush), but are also reported via den.
    function automatic op_class_t classify(input logic [EXP_W-1:0]  e,
                                           input logic [FRAC_W-1:0] f);
        op_class_t c;
        logic      e_zero;
        logic      e_max;
        logic      f_zero;
        e_zero = (e == '0);
        e_max  = (e == {EXP_W{1'b1}});
        f_zero = (f == '0);
        c.zero = e_zero;
        c.den  = e_zero & ~f_zero;
        c.inf  = e_max & f_zero;
        c.nan  = e_max & ~f_zero;
        // Hidden bit only for normal numbers; specials present a 0 mantissa.
        c.man  = (e_zero | e_max) ? '0 : {1'b1, f};
        return c;
    endfunction

    // Pipeline control
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_adv;
    logic s2_adv;
    logic in_xfer;
    logic s2_load;

    // Stage 1 payload
    logic [OpW-1:0] s1_a_q;
    logic [OpW-1:0] s1_b_q;

    // Stage 2 payload
    logic              s2_sign_q;
    logic [EXP_W-1:0]  s2_exp_a_q;
    logic [EXP_W-1:0]  s2_exp_b_q;
    logic [FRAC_W:0]   s2_man_a_q;
    logic [FRAC_W:0]   s2_man_b_q;
    logic              s2_zero_q;
    logic              s2_inf_q;
    logic              s2_nan_q;
    logic              s2_den_q;

    // Stage 2 next-state (classified view of the stage 1 pair)
    logic              sign_d;
    logic [EXP_W-1:0]  exp_a_d;
    logic [EXP_W-1:0]  exp_b_d;
    logic [FRAC_W:0]   man_a_d;
    logic [FRAC_W:0]   man_b_d;
    logic              zero_d;
    logic              inf_d;
    logic              nan_d;
    logic              den_d;
    op_class_t         cls_a;
    op_class_t         cls_b;

    assign s2_adv          = ~s2_valid_q | bus_io.out_ready;
    assign s1_adv          = ~s1_valid_q | s2_adv;
    assign bus_io.in_ready = s1_adv;
    assign in_xfer         = bus_io.in_valid & s1_adv;
    assign s2_load         = s1_adv & s1_valid_q;

    // Stage 1: capture the raw operand pair on an accepted input.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (in_xfer) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= bus_io.op_a;
            s1_b_q     <= bus_io.op_b;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Unpack both operands and derive the mutually exclusive pair flags.
    always_comb begin
        sign_d  = s1_a_q[OpW-1] ^ s1_b_q[OpW-1];
        exp_a_d = s1_a_q[OpW-2 -: EXP_W];
        exp_b_d = s1_b_q[OpW-2 -: EXP_W];
        cls_a   = classify(exp_a_d, s1_a_q[FRAC_W-1:0]);
        cls_b   = classify(exp_b_d, s1_b_q[FRAC_W-1:0]);
        man_a_d = cls_a.man;
        man_b_d = cls_b.man;
        // inf * 0 is invalid and therefore NaN, which masks zero and inf.
        nan_d   = cls_a.nan | cls_b.nan | (cls_a.inf & cls_b.zero) | (cls_a.zero & cls_b.inf);
        inf_d   = (cls_a.inf | cls_b.inf) & ~nan_d;
        zero_d  = (cls_a.zero | cls_b.zero) & ~nan_d;
        den_d   = cls_a.den | cls_b.den;
    end

    // Stage 2: register the classified result; hold it while stalled.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_a_q <= '0;
            s2_exp_b_q <= '0;
            s2_man_a_q <= '0;
            s2_man_b_q <= '0;
            s2_zero_q  <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_nan_q   <= 1'b0;
            s2_den_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_sign_q  <= sign_d;
            s2_exp_a_q <= exp_a_d;
            s2_exp_b_q <= exp_b_d;
            s2_man_a_q <= man_a_d;
            s2_man_b_q <= man_b_d;
            s2_zero_q  <= zero_d;
            s2_inf_q   <= inf_d;
            s2_nan_q   <= nan_d;
            s2_den_q   <= den_d;
        end else if (s2_adv) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign bus_io.out_valid         = s2_valid_q;
    assign bus_io.sign_out          = s2_sign_q;
    assign bus_io.exp_a             = s2_exp_a_q;
    assign bus_io.exp_b             = s2_exp_b_q;
    assign bus_io.man_a             = s2_man_a_q;
    assign bus_io.man_b             = s2_man_b_q;
    assign bus_io.initial_zero_flag = s2_zero_q;
    assign bus_io.initial_inf_flag  = s2_inf_q;
    assign bus_io.initial_nan_flag  = s2_nan_q;
    assign bus_io.denorm_flushed    = s2_den_q;

endmodule

// File: tb/tb_fp_mul_operand_unpack.sv
// Bench for fp_mul_operand_unpack: directed special-value cases, backpressure,
// full-rate streaming, reset with data in flight and a random handshake phase,
// all scored against an arithmetic reference model and an in-order queue.
module tb_fp_mul_operand_unpack;

    // {sign, exp_a, exp_b, man_a, man_b, zero, inf, nan, den}
    typedef logic [68:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   mon_en = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    vec_t exp_q[$];

    fp_mul_operand_unpack_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    fp_mul_operand_unpack #(.EXP_W(8), .FRAC_W(23)) dut (
        .CLK    (clk),
        .RST    (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t obs_vec();
        return {bus.sign_out, bus.exp_a, bus.exp_b, bus.man_a, bus.man_b,
                bus.initial_zero_flag, bus.initial_inf_flag, bus.initial_nan_flag,
                bus.denorm_flushed};
    endfunction

    // Reference: IEEE field semantics computed with plain integer arithmetic.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        int unsigned ea, eb, fa, fb, ma, mb, sg;
        bit za, zb, ia, ib, na, nb, nan, inf, zero, den;
        ea = (a >> 23) % 256;
        eb = (b >> 23) % 256;
        fa = a % (1 << 23);
        fb = b % (1 << 23);
        sg = ((a >> 31) + (b >> 31)) % 2;
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        ma = (ea > 0 && ea < 255) ? fa + (1 << 23) : 0;
        mb = (eb > 0 && eb < 255) ? fb + (1 << 23) : 0;
        nan  = na || nb || (ia && zb) || (za && ib);
        inf  = (ia || ib) && !nan;
        zero = (za || zb) && !nan;
        den  = (za && fa != 0) || (zb && fb != 0);
        return {1'(sg), 8'(ea), 8'(eb), 24'(ma), 24'(mb), zero, inf, nan, den};
    endfunction

    // Random operand biased towards the special classes.
    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v[30:0] = '0;
            1: begin v[30:23] = 8'h00; v[0] = 1'b1; end
            2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            3: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            default: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h80;
        endcase
        return v;
    endfunction

    // Scoreboard: decides handshakes at negedge (inputs stable until next posedge).
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                check_eq("in_ready", bus.in_ready,
                         (exp_q.size() < 2) || bus.out_ready);
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_out", bus.out_valid, 1'b0);
                    end else begin
                        check_eq("out_data", obs_vec(), exp_q[0]);
                        if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            n_out++;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op_a, bus.op_b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single pair through an empty pipeline; checks latency and a constant result.
    task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input vec_t want);
        int n;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, n, 1);
        check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
        check_eq({tag, "_vec"}, obs_vec(), want);
        step();
    endtask

    logic [31:0] pa[4];
    logic [31:0] pb[4];

    initial begin
        int acc, guard, base, nv, first, last;
        bit rdy, rdy_all;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;

        // Reset state
        step();
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_outputs", obs_vec(), '0);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        mon_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Basic and special-value pairs
        run_pair("basic", 32'h3FC00000, 32'h40000000,
                 {1'b0, 8'h7F, 8'h80, 24'hC00000, 24'h800000, 4'b0000});
        run_pair("negzero", 32'h80000000, 32'h3F800000,
                 {1'b1, 8'h00, 8'h7F, 24'h000000, 24'h800000, 4'b1000});
        run_pair("denorm", 32'h00000001, 32'h3F800000,
                 {1'b0, 8'h00, 8'h7F, 24'h000000, 24'h800000, 4'b1001});
        run_pair("inf_x_zero", 32'h7F800000, 32'h00000000,
                 {1'b0, 8'hFF, 8'h00, 24'h000000, 24'h000000, 4'b0010});
        run_pair("inf_x_two", 32'h7F800000, 32'h40000000,
                 {1'b0, 8'hFF, 8'h80, 24'h000000, 24'h800000, 4'b0100});
        run_pair("nan_x_one", 32'h7FC00000, 32'h3F800000,
                 {1'b0, 8'hFF, 8'h7F, 24'h000000, 24'h800000, 4'b0010});

        // Backpressure: only two pairs fit while the output stalls.
        pa = '{32'h3F800000, 32'h40400000, 32'hC0A00000, 32'h41100000};
        pb = '{32'h40000000, 32'hBF000000, 32'h3E800000, 32'h42C80000};
        bus.out_ready = 1'b0;
        base = n_out;
        acc  = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus.in_valid = 1'b1;
            bus.op_a     = pa[acc];
            bus.op_b     = pb[acc];
            @(negedge clk);
            rdy = bus.in_ready;
            step();
            if (rdy) acc++;
        end
        check_eq("bp_accepted", acc, 2);
        @(negedge clk);
        check_eq("bp_in_ready", bus.in_ready, 1'b0);
        check_eq("bp_hold_valid", bus.out_valid, 1'b1);
        check_eq("bp_hold_data", obs_vec(), model(pa[0], pb[0]));
        step();
        bus.out_ready = 1'b1;
        guard = 0;
        while (acc < 4 && guard < 20) begin
            bus.op_a = pa[acc];
            bus.op_b = pb[acc];
            @(negedge clk);
            rdy = bus.in_ready;
            step();
            if (rdy) acc++;
            guard++;
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        check_eq("bp_out_count", n_out - base, 4);

        // Full throughput: 16 back-to-back pairs
        nv = 0;
        first = -1;
        last = -1;
        rdy_all = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.in_valid = (cyc < 16);
            bus.op_a     = rand_op();
            bus.op_b     = rand_op();
            @(negedge clk);
            if (cyc < 16 && !bus.in_ready) rdy_all = 1'b0;
            if (bus.out_valid) begin
                nv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            step();
        end
        check_eq("tp_in_ready", rdy_all, 1'b1);
        check_eq("tp_valid_cycles", nv, 16);
        check_eq("tp_first", first, 2);
        check_eq("tp_span", last - first + 1, 16);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            bus.op_a = rand_op();
            bus.op_b = rand_op();
            step();
        end
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check_eq("rst_mid_valid", bus.out_valid, 1'b0);
        check_eq("rst_mid_outputs", obs_vec(), '0);
        check_eq("rst_mid_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        nv = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
            step();
        end
        check_eq("rst_no_stale", nv, 0);

        // Random handshakes
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.op_a      = rand_op();
            bus.op_b      = rand_op();
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        check_eq("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
